sopc_2_reset_sequencer: RTL and testbench
=========================================

// Module: sopc_2_reset_sequencer
// PURPOSE
//  Consumes the watchdog's resetrequest pulse, an external push-button and a software key.
//  Turns any of them into a staged system reset: peripherals are released first, the CPU last.
//  Latches the reset cause in a register that sys resets do not clear, so software can read why it rebooted.
//  Avalon-MM slave, 16-bit data, sits beside the watchdog on the same clk domain.
// PARAMETERS
//  HOLD_CYCLES     16     cycles both resets stay asserted after a trigger (>=1)
//  STAGGER_CYCLES  8      cycles periph_reset is low while cpu_reset is still high (>=1)
//  SW_KEY          8'hA5  writedata[7:0] value at addr 2 that triggers a software reset
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high power-on reset (only thing that clears CAUSE/COUNT)
//  wdt_resetrequest  in   1   watchdog resetrequest, multi-cycle pulse, same clk domain
//  ext_reset_req_n   in   1   asynchronous push-button, active-low
//  address           in   2   register select
//  chipselect        in   1   slave select
//  write_n           in   1   active-low write strobe
//  writedata         in   16  write data
//  readdata          out  16  registered read data, 1-cycle latency
//  periph_reset      out  1   active-high peripheral reset
//  cpu_reset         out  1   active-high CPU reset
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  On reset: state=ASSERT, hold counter=HOLD_CYCLES, cpu_reset=1, periph_reset=1, readdata=0.
//    Also on reset: CAUSE=16'h0001, CONTROL=16'h0003, COUNT=0, sync FFs=1.
//  Events (evaluated every cycle, combinational on registered history):
//    wdt_ev = wdt_resetrequest & ~wdt_prev & CONTROL[0]  (rising edge only; one pulse = one event)
//    ext_ev = ~ext_s2 & ext_prev & CONTROL[1]; ext_s1/ext_s2 is a 2-FF synchroniser, ext_prev=delayed ext_s2
//    sw_ev  = chipselect & ~write_n & addr==2 & writedata[7:0]==SW_KEY; other values ignored
//    trig   = wdt_ev | ext_ev | sw_ev
//  FSM: ASSERT -> REL_PERIPH -> RUN; outputs are registers updated on the same edge as the state.
//    ASSERT: cpu=1, periph=1; leave after exactly HOLD_CYCLES cycles.
//    REL_PERIPH: cpu=1, periph=0; leave after exactly STAGGER_CYCLES cycles.
//    RUN: cpu=0, periph=0.
//    trig in any state -> ASSERT with counter reloaded; both outputs high after that edge.
//    Retrigger during ASSERT/REL_PERIPH restarts the full sequence.
//  Latency:
//    wdt/sw trigger seen at edge k -> outputs high after edge k, periph low after k+HOLD, cpu low after k+HOLD+STAGGER.
//    ext_reset_req_n low at sample edge k -> event at edge k+2.
//  Registers (read via mux, registered into readdata):
//    0 CAUSE  bit0 POR, bit1 WDT, bit2 EXT, bit3 SW; sticky; write-1-to-clear; set wins over same-cycle clear
//    1 CONTROL bit0 wdt_enable, bit1 ext_enable; R/W; upper bits read 0
//    2 SWRESET write-only key; reads 0
//    3 COUNT  [7:0] watchdog-reset count, saturates at 255; any write clears; increment wins (result 1)
//  Simultaneous events set all matching CAUSE bits in one cycle; COUNT increments only on wdt_ev.
//  Disabled source: no state change, no CAUSE bit, no COUNT change.
//  Register access is legal while cpu_reset is high (block reset only by reset).
// TESTING
//  POR: reset 1 for 3 cycles then 0 -> periph low at cycle 16 and cpu low at cycle 24 after release; CAUSE reads 0x0001.
//  WDT: resetrequest high 2 cycles in RUN -> outputs high 16 cycles, periph low 8 before cpu.
//    CAUSE=0x0003; COUNT=1; a second pulse gives COUNT=2.
//  SW key: write 0x5A to addr 2 -> no reset; write 0xA5 -> sequence starts after that edge; CAUSE bit3 set.
//  EXT: drive ext_reset_req_n low asynchronously -> outputs high exactly 2 edges after first low sample; CAUSE bit2.
//    With CONTROL=0x0001, same stimulus -> no reset.
//  Retrigger: second wdt pulse 5 cycles into REL_PERIPH -> ASSERT again for full 16+8; COUNT +1.
//  Collisions: W1C 0x0002 to CAUSE in same cycle as wdt_ev -> bit1 remains 1.
//    COUNT=255 plus wdt_ev -> stays 255. Clear-write plus wdt_ev -> COUNT=1.

Source files
------------

// File: rtl/sopc_2_reset_sequencer.sv
// Staged system reset sequencer: watchdog, push-button and software key sources,
// peripherals released before the CPU, with a POR-only cause/count register file.
module sopc_2_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter logic [7:0]  SW_KEY         = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wdt_resetrequest,
    input  logic        ext_reset_req_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        periph_reset,
    output logic        cpu_reset
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_ASSERT     = 2'd0,
        ST_REL_PERIPH = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [3:0]  cause;
    logic [1:0]  control;
    logic [7:0]  count;
    logic        ext_s1;
    logic        ext_s2;
    logic        ext_prev;
    logic        wdt_prev;

    logic        wr;
    logic        wdt_ev;
    logic        ext_ev;
    logic        sw_ev;
    logic        trig;
    logic [3:0]  cause_clr;
    logic [3:0]  cause_next;
    logic [7:0]  count_next;
    logic [15:0] rd_mux;

    // Only the low key byte and register bits are decoded.
    wire unused_wdata = ^writedata[15:8];

    // Event detection and next register values from registered history.
    always_comb begin
        wr         = chipselect & ~write_n;
        wdt_ev     = wdt_resetrequest & ~wdt_prev & control[0];
        ext_ev     = ~ext_s2 & ext_prev & control[1];
        sw_ev      = wr & (address == 2'd2) & (writedata[7:0] == SW_KEY);
        trig       = wdt_ev | ext_ev | sw_ev;

        cause_clr  = (wr && address == 2'd0) ? writedata[3:0] : 4'b0000;
        cause_next = (cause & ~cause_clr) | {sw_ev, ext_ev, wdt_ev, 1'b0};

        count_next = count;
        if (wdt_ev) begin
            if (wr && address == 2'd3) begin
                count_next = 8'd1;
            end else if (count != 8'hFF) begin
                count_next = count + 8'd1;
            end
        end else if (wr && address == 2'd3) begin
            count_next = 8'd0;
        end

        rd_mux = 16'h0000;
        case (address)
            2'd0:    rd_mux = {12'h000, cause};
            2'd1:    rd_mux = {14'h0000, control};
            2'd3:    rd_mux = {8'h00, count};
            default: rd_mux = 16'h0000;
        endcase
    end

    // Reset sequencing FSM; any trigger restarts the full hold + stagger sequence.
    always_ff @(posedge clk) begin
        if (reset || trig) begin
            state        <= ST_ASSERT;
            cnt          <= CNT_W'(HOLD_CYCLES);
            cpu_reset    <= 1'b1;
            periph_reset <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == CNT_W'(1)) begin
                        state        <= ST_REL_PERIPH;
                        cnt          <= CNT_W'(STAGGER_CYCLES);
                        periph_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_REL_PERIPH: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        cpu_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cpu_reset    <= 1'b0;
                    periph_reset <= 1'b0;
                end
                default: begin
                    state        <= ST_ASSERT;
                    cnt          <= CNT_W'(HOLD_CYCLES);
                    cpu_reset    <= 1'b1;
                    periph_reset <= 1'b1;
                end
            endcase
        end
    end

    // Register file, input history and read pipeline; cleared only by power-on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause    <= 4'b0001;
            control  <= 2'b11;
            count    <= 8'd0;
            ext_s1   <= 1'b1;
            ext_s2   <= 1'b1;
            ext_prev <= 1'b1;
            wdt_prev <= 1'b0;
            readdata <= 16'h0000;
        end else begin
            cause    <= cause_next;
            count    <= count_next;
            if (wr && address == 2'd1) begin
                control <= writedata[1:0];
            end
            ext_s1   <= ext_reset_req_n;
            ext_s2   <= ext_s1;
            ext_prev <= ext_s2;
            wdt_prev <= wdt_resetrequest;
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sopc_2_reset_sequencer.sv
// Scoreboard bench for sopc_2_reset_sequencer: directed scenarios plus random traffic
// checked against a cycles-since-trigger reference model.
module tb_sopc_2_reset_sequencer;

    localparam int unsigned HOLD    = 16;
    localparam int unsigned STAGGER = 8;

    logic        clk;
    logic        reset;
    logic        wdt_resetrequest;
    logic        ext_reset_req_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        periph_reset;
    logic        cpu_reset;

    int errors = 0;
    int checks = 0;

    sopc_2_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAGGER),
        .SW_KEY        (8'hA5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wdt_resetrequest(wdt_resetrequest),
        .ext_reset_req_n (ext_reset_req_n),
        .address         (address),
        .chipselect      (chipselect),
        .write_n         (write_n),
        .writedata       (writedata),
        .readdata        (readdata),
        .periph_reset    (periph_reset),
        .cpu_reset       (cpu_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time since the last trigger plus plain register variables.
    int unsigned m_since = 0;
    bit          m_valid = 0;
    logic [3:0]  m_cause = 4'd0;
    logic [1:0]  m_ctrl  = 2'd0;
    int          m_count = 0;
    bit          m_wdt_last = 0;
    bit          h0 = 1, h1 = 1, h2 = 1;

    always @(posedge clk) begin
        bit w_ev, e_ev, s_ev, wr;
        if (reset) begin
            m_since = 0; m_cause = 4'd1; m_ctrl = 2'd3; m_count = 0;
            m_wdt_last = 0; h0 = 1; h1 = 1; h2 = 1;
        end else begin
            wr   = chipselect && !write_n;
            w_ev = wdt_resetrequest && !m_wdt_last && m_ctrl[0];
            e_ev = !h1 && h2 && m_ctrl[1];
            s_ev = wr && address == 2'd2 && writedata[7:0] == 8'hA5;
            if (wr && address == 2'd0) m_cause = m_cause & ~writedata[3:0];
            m_cause = m_cause | {s_ev, e_ev, w_ev, 1'b0};
            if (wr && address == 2'd1) m_ctrl = writedata[1:0];
            if (wr && address == 2'd3) m_count = 0;
            if (w_ev && m_count < 255) m_count = m_count + 1;
            if (w_ev || e_ev || s_ev) m_since = 0;
            else if (m_since < 1000) m_since = m_since + 1;
            m_wdt_last = wdt_resetrequest;
            h2 = h1; h1 = h0; h0 = ext_reset_req_n;
        end
        m_valid = 1;
    end

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {12'h000, m_cause};
            2'd1:    return {14'h0000, m_ctrl};
            2'd3:    return 16'(m_count);
            default: return 16'h0000;
        endcase
    endfunction

    // Scoreboard of expected read data, popped by the monitor.
    logic [15:0] sb[$];
    bit          rd_pend = 0;

    always @(posedge clk) rd_pend <= chipselect && write_n && !reset;

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (periph_reset !== (m_since < HOLD)) begin
                errors++;
                $display("FAIL periph_reset t=%0t got=%0b exp=%0b", $time, periph_reset, (m_since < HOLD));
            end
            checks++;
            if (cpu_reset !== (m_since < HOLD + STAGGER)) begin
                errors++;
                $display("FAIL cpu_reset t=%0t got=%0b exp=%0b", $time, cpu_reset, (m_since < HOLD + STAGGER));
            end
        end
        if (rd_pend) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL readdata t=%0t got=%h exp=<none queued>", $time, readdata);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL readdata t=%0t got=%h exp=%h", $time, readdata, e);
                end
            end
        end
    end

    // Bus tasks: called just after a falling edge, return at the next falling edge.
    task automatic bus(input bit cs, input bit wn, input logic [1:0] a, input logic [15:0] d,
                       input bit use_exp, input logic [15:0] exp_val);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        if (cs && wn) sb.push_back(use_exp ? exp_val : model_read(a));
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus(1'b1, 1'b0, a, d, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b1, 1'b1, a, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic rd_exp(input logic [1:0] a, input logic [15:0] e);
        bus(1'b1, 1'b1, a, 16'h0, 1'b1, e);
    endtask

    task automatic wdt_pulse(input int len);
        wdt_resetrequest = 1'b1;
        idle(len);
        wdt_resetrequest = 1'b0;
    endtask

    task automatic ext_press(input int len);
        #2 ext_reset_req_n = 1'b0;
        idle(len);
        #3 ext_reset_req_n = 1'b1;
        idle(1);
    endtask

    initial begin
        reset = 1'b1; wdt_resetrequest = 1'b0; ext_reset_req_n = 1'b1;
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Power-on sequence and reset values
        idle(30);
        rd_exp(2'd0, 16'h0001);
        rd_exp(2'd1, 16'h0003);
        rd_exp(2'd3, 16'h0000);
        rd_exp(2'd2, 16'h0000);

        // Watchdog pulses
        wdt_pulse(2); idle(30);
        rd_exp(2'd0, 16'h0003);
        rd_exp(2'd3, 16'h0001);
        wdt_pulse(2); idle(30);
        rd_exp(2'd3, 16'h0002);
        wr(2'd0, 16'h000F);
        rd_exp(2'd0, 16'h0000);

        // Software key: wrong value ignored, correct value triggers
        wr(2'd2, 16'h005A); idle(30);
        rd_exp(2'd0, 16'h0000);
        wr(2'd2, 16'h00A5); idle(30);
        rd_exp(2'd0, 16'h0008);
        wr(2'd0, 16'h000F);

        // Push-button, enabled then disabled
        ext_press(4); idle(30);
        rd_exp(2'd0, 16'h0004);
        wr(2'd0, 16'h000F);
        wr(2'd1, 16'h0001);
        ext_press(4); idle(30);
        rd_exp(2'd0, 16'h0000);
        wr(2'd1, 16'h0000);
        wdt_pulse(2); idle(30);
        rd_exp(2'd3, 16'h0002);
        wr(2'd1, 16'h0003);

        // Retrigger five cycles into peripheral release
        wdt_pulse(2); idle(19);
        wdt_pulse(2); idle(30);
        rd_exp(2'd3, 16'h0004);

        // W1C collision with a watchdog event keeps the cause bit
        wr(2'd0, 16'h000F);
        idle(2);
        wdt_resetrequest = 1'b1;
        wr(2'd0, 16'h0002);
        wdt_resetrequest = 1'b0;
        rd_exp(2'd0, 16'h0002);

        // Count clear collides with increment
        idle(2);
        wdt_resetrequest = 1'b1;
        wr(2'd3, 16'h0000);
        wdt_resetrequest = 1'b0;
        rd_exp(2'd3, 16'h0001);

        // Saturation at 255
        repeat (260) begin wdt_pulse(1); idle(1); end
        rd_exp(2'd3, 16'h00FF);
        wdt_pulse(1); idle(1);
        rd_exp(2'd3, 16'h00FF);
        wdt_resetrequest = 1'b1;
        wr(2'd3, 16'h0000);
        wdt_resetrequest = 1'b0;
        rd_exp(2'd3, 16'h0001);
        idle(30);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            int op;
            if ($urandom_range(0, 7) == 0) wdt_resetrequest = ~wdt_resetrequest;
            if ($urandom_range(0, 29) == 0) begin #2 ext_reset_req_n = ~ext_reset_req_n; end
            op = $urandom_range(0, 11);
            case (op)
                0: wr(2'($urandom_range(0, 3)),
                      $urandom_range(0, 1) ? 16'h00A5 : 16'($urandom));
                1: wr(2'd1, 16'h0003);
                2, 3: rd(2'($urandom_range(0, 3)));
                default: idle(1);
            endcase
        end
        wdt_resetrequest = 1'b0;
        ext_reset_req_n = 1'b1;
        wr(2'd1, 16'h0003);
        idle(30);
        rd(2'd0);
        rd(2'd3);

        // Mid-run power-on reset restores cause and count
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(30);
        rd_exp(2'd0, 16'h0001);
        rd_exp(2'd3, 16'h0000);
        rd_exp(2'd1, 16'h0003);
        idle(3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
